// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word loads/stores on an internal data RAM,
// a post-reset clear sweep, sticky access-error flags and saturating counters.
module mem_stage #(
   parameter int ADDR_W = 6,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [70:0]       ex_mem_in,
   output logic [35:0]       mem_wb_out,
   output logic              busy,
   output logic              misalign_err,
   output logic              range_err,
   output logic [CNT_W-1:0]  load_cnt,
   output logic [CNT_W-1:0]  store_cnt
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              clear_we;
   logic              run;
   logic [ADDR_W-1:0] ptr;

   logic [31:0]       ram [DEPTH];

   // EX/MEM bundle fields
   logic              reg_write;
   logic              mem_to_reg;
   logic              mem_read;
   logic              mem_write;
   logic [31:0]       alu_result;
   logic [31:0]       store_data;
   logic [2:0]        rd;

   assign reg_write  = ex_mem_in[70];
   assign mem_to_reg = ex_mem_in[69];
   assign mem_read   = ex_mem_in[68];
   assign mem_write  = ex_mem_in[67];
   assign alu_result = ex_mem_in[66:35];
   assign store_data = ex_mem_in[34:3];
   assign rd         = ex_mem_in[2:0];

   logic [ADDR_W-1:0] word_addr;
   logic              misalign_hit;
   logic              range_hit;
   logic              access;
   logic              legal;
   logic              do_store;
   logic              do_load;

   assign word_addr    = alu_result[ADDR_W+1:2];
   assign misalign_hit = |alu_result[1:0];
   assign range_hit    = |alu_result[31:ADDR_W+2];
   assign access       = mem_read | mem_write;
   assign legal        = access & ~misalign_hit & ~range_hit;
   // A combined read/write request is a store; it never produces a load.
   assign do_store     = run & legal & mem_write;
   assign do_load      = run & legal & mem_read & ~mem_write;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state <= CLEAR;
      else     state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (&ptr) state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = CLEAR;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy     = 1'b0;
      clear_we = 1'b0;
      run      = 1'b0;
      case (state)
         CLEAR: begin
            busy     = 1'b1;
            clear_we = 1'b1;
         end
         RUN:     run = 1'b1;
         default: busy = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)           ptr <= '0;
      else if (clear_we) ptr <= ptr + ADDR_W'(1);
   end

   // RAM write port: sweep writes zero, otherwise legal stores
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (clear_we)      ram[ptr]       <= 32'h0;
         else if (do_store) ram[word_addr] <= store_data;
      end
   end

   logic        reg_write_q;
   logic        mem_to_reg_q;
   logic [2:0]  rd_q;
   logic [31:0] alu_q;
   logic [31:0] ram_q;

   // ram_q only moves on a legal load, so mem_to_reg without one replays the last load
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         rd_q         <= 3'd0;
         alu_q        <= 32'h0;
         ram_q        <= 32'h0;
      end else if (run) begin
         reg_write_q  <= reg_write & ~(access & ~legal);
         mem_to_reg_q <= mem_to_reg;
         rd_q         <= rd;
         alu_q        <= alu_result;
         if (do_load) ram_q <= ram[word_addr];
      end
   end

   assign mem_wb_out = {reg_write_q, rd_q, (mem_to_reg_q ? ram_q : alu_q)};

   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_err <= 1'b0;
         range_err    <= 1'b0;
      end else if (run && access) begin
         if (misalign_hit) misalign_err <= 1'b1;
         if (range_hit)    range_err    <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         load_cnt  <= '0;
         store_cnt <= '0;
      end else begin
         if (do_load && load_cnt != '1)   load_cnt  <= load_cnt + CNT_W'(1);
         if (do_store && store_cnt != '1) store_cnt <= store_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Randomised scoreboard bench for mem_stage against a word-array reference model,
// with a second instance built with 2-bit counters to exercise saturation.
module tb_mem_stage;

   localparam int W = 74;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [70:0] ex_mem_in = '0;

   logic [35:0] mem_wb_out, mem_wb_out2;
   logic        busy, busy2, misalign_err, misalign_err2, range_err, range_err2;
   logic [15:0] load_cnt, store_cnt;
   logic [1:0]  load_cnt2, store_cnt2;

   mem_stage #(.ADDR_W(6), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .ex_mem_in(ex_mem_in), .mem_wb_out(mem_wb_out), .busy(busy),
      .misalign_err(misalign_err), .range_err(range_err), .load_cnt(load_cnt), .store_cnt(store_cnt)
   );

   mem_stage #(.ADDR_W(6), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .ex_mem_in(ex_mem_in), .mem_wb_out(mem_wb_out2), .busy(busy2),
      .misalign_err(misalign_err2), .range_err(range_err2), .load_cnt(load_cnt2), .store_cnt(store_cnt2)
   );

   // clock / reset
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete, got %0d cycles required fewer", cyc);
      $fatal(1);
   end

   // reference model
   logic [31:0] mem_m [64];
   logic [31:0] last_load;
   int          ld_m, st_m, ld2_m, st2_m;
   logic        mis_m, rng_m;

   // scoreboard
   logic [W-1:0] exp_q[$];
   int           due_q[$];
   int           checks = 0;
   int           errors = 0;

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) mem_m[i] = 32'h0;
      last_load = 32'h0;
      ld_m = 0; st_m = 0; ld2_m = 0; st2_m = 0;
      mis_m = 1'b0; rng_m = 1'b0;
   endtask

   // driver: present one instruction, predict its result, consume one cycle
   task automatic issue(input logic rw, input logic m2r, input logic mr, input logic mw,
                        input logic [31:0] alu, input logic [31:0] sd, input logic [2:0] rd);
      logic        acc, ok, rw_out;
      logic [31:0] wb;
      int          a;
      ex_mem_in = {rw, m2r, mr, mw, alu, sd, rd};
      acc = mr | mw;
      ok  = (alu % 4 == 0) && (alu < 32'd256);
      a   = int'(alu / 4) % 64;
      rw_out = rw;
      if (acc && !ok) begin
         rw_out = 1'b0;
         if (alu % 4 != 0) mis_m = 1'b1;
         if (alu >= 32'd256) rng_m = 1'b1;
      end else if (acc && mw) begin
         mem_m[a] = sd;
         if (st_m < 65535) st_m++;
         if (st2_m < 3) st2_m++;
      end else if (acc) begin
         last_load = mem_m[a];
         if (ld_m < 65535) ld_m++;
         if (ld2_m < 3) ld2_m++;
      end
      wb = m2r ? last_load : alu;
      exp_q.push_back({rw_out, rd, wb, mis_m, rng_m, ld_m[15:0], st_m[15:0], ld2_m[1:0], st2_m[1:0]});
      due_q.push_back(cyc + 1);
      @(posedge clk); #1;
   endtask

   task automatic rand_instr();
      logic [31:0] alu;
      int          sel;
      sel = $urandom_range(0, 9);
      alu = {24'h0, 2'b00, 6'($urandom_range(0, 63)), 2'b00};
      if (sel == 7) alu = alu | 32'($urandom_range(1, 3));
      else if (sel == 8) alu = ($urandom & 32'hFFFF_FF00) | 32'h100 | alu;
      else if (sel == 9) alu = $urandom;
      issue(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), alu, $urandom, 3'($urandom));
   endtask

   // apply reset on the next edge; inputs are scrambled to show they are ignored
   task automatic do_reset();
      rst = 1'b1;
      ex_mem_in = {$urandom, $urandom, $urandom};
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      chk("reset_wb", mem_wb_out, 36'h0);
      chk("reset_flags", {34'h0, misalign_err, range_err}, 36'h0);
      chk("reset_cnts", {4'h0, load_cnt, store_cnt}, 36'h0);
   endtask

   task automatic sweep_wait(input int limit);
      int n;
      n = 0;
      while (busy && n < limit) begin
         if (mem_wb_out !== 36'h0) chk("clear_wb_zero", mem_wb_out, 36'h0);
         ex_mem_in = {$urandom, $urandom, $urandom};
         @(posedge clk); #1;
         n++;
      end
      chk("busy_cycles", 36'(n), 36'd64);
      chk("clear_cnts_held", {4'h0, load_cnt, store_cnt}, 36'h0);
   endtask

   // monitor: each output is due one cycle after its instruction was accepted
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         e = exp_q.pop_front();
         void'(due_q.pop_front());
         chk("mem_wb_out", mem_wb_out, e[73:38]);
         chk("err_flags", {34'h0, misalign_err, range_err}, {34'h0, e[37:36]});
         chk("cnt16", {4'h0, load_cnt, store_cnt}, {4'h0, e[35:4]});
         chk("cnt2", {32'h0, load_cnt2, store_cnt2}, {32'h0, e[3:0]});
      end
   end

   initial begin
      model_reset();
      @(posedge clk); #1;
      // clear sweep, then every word reads back zero
      do_reset();
      sweep_wait(200);
      for (int i = 0; i < 64; i++) issue(1'b1, 1'b1, 1'b1, 1'b0, 32'(i * 4), $urandom, 3'($urandom));
      // store then immediate load of the same word
      issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd0);
      issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 3'd3);
      // plain ALU pass-through
      issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, $urandom, 3'd5);
      // misaligned load, out-of-range store, then confirm word 0 untouched
      issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h12, 32'h0, 3'd1);
      issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'hCAFEF00D, 3'd2);
      issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 3'd4);
      // store counter saturation in the 2-bit instance, incl. combined read/write
      for (int i = 0; i < 4; i++) issue(1'b0, 1'b0, 1'b0, 1'b1, 32'(4 * (i + 20)), $urandom, 3'd0);
      issue(1'b0, 1'b0, 1'b1, 1'b1, 32'h60, 32'h5A5A_A5A5, 3'd0);
      issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h60, 32'h0, 3'd6);
      // mem_to_reg without a legal load replays the previous load data
      issue(1'b1, 1'b1, 1'b0, 1'b0, 32'h777, 32'h0, 3'd7);
      repeat (300) rand_instr();
      // reset in the middle of a sweep restarts it
      do_reset();
      repeat (30) begin
         ex_mem_in = {$urandom, $urandom, $urandom};
         @(posedge clk); #1;
      end
      chk("busy_mid_sweep", {35'h0, busy}, 36'h1);
      do_reset();
      sweep_wait(200);
      for (int i = 0; i < 64; i++) issue(1'b1, 1'b1, 1'b1, 1'b0, 32'(i * 4), 32'h0, 3'($urandom));
      repeat (100) rand_instr();
      issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
      @(posedge clk); #1;
      chk("queue_drained", 36'(exp_q.size()), 36'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
